// File: rtl/async_dff_block.sv
// Parameterised D register with synchronous reset and preset.
// Latency: one clk edge from d/set/reset to q_out. Backpressure: none, it captures every edge.
module async_dff_block #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] SET_VALUE   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] qcomp_out
);

  logic [WIDTH-1:0] q;

  // Reset outranks set, and both outrank data.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (set) begin
      q <= SET_VALUE;
    end else begin
      q <= d;
    end
  end

  // Both outputs come straight off the register, so no input reaches them combinationally.
  assign q_out     = q;
  assign qcomp_out = ~q;

endmodule

// File: tb/tb_async_dff_block.sv
// Scoreboard bench for async_dff_block: default 1-bit instance plus an 8-bit instance with custom reset/set values.
module tb_async_dff_block;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       set = 1'b0;
  logic       d1 = 1'b0;
  logic [7:0] d8 = '0;
  logic       q1, qc1;
  logic [7:0] q8, qc8;

  typedef struct packed {
    logic       q1;
    logic [7:0] q8;
  } exp_t;

  exp_t exp_q[$];
  exp_t prev;
  bit   started = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  async_dff_block dut1 (
    .clk(clk), .reset(reset), .set(set), .d(d1), .q_out(q1), .qcomp_out(qc1)
  );

  async_dff_block #(.WIDTH(8), .RESET_VALUE(8'hA5), .SET_VALUE(8'h3C)) dut8 (
    .clk(clk), .reset(reset), .set(set), .d(d8), .q_out(q8), .qcomp_out(qc8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Drives one edge's inputs, optionally with a 1 ns glitch on d, then checks the result after the edge.
  task automatic cycle(input logic r, input logic s, input logic [7:0] dv, input bit glitch);
    exp_t e, got_e;
    reset = r;
    set   = s;
    d1    = dv[0];
    d8    = dv;
    if (r)      e = '{q1: 1'b0,  q8: 8'hA5};
    else if (s) e = '{q1: 1'b1,  q8: 8'h3C};
    else        e = '{q1: dv[0], q8: dv};
    exp_q.push_back(e);
    if (glitch) begin
      #1 d1 = ~dv[0]; d8 = ~dv;
      #1 d1 = dv[0];  d8 = dv;
    end else begin
      #2;
    end
    if (started) begin
      check("mid_q1", {31'b0, q1}, {31'b0, prev.q1});
      check("mid_q8", {24'b0, q8}, {24'b0, prev.q8});
    end
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    check("q1",    {31'b0, q1},  {31'b0, got_e.q1});
    check("qc1",   {31'b0, qc1}, {31'b0, ~got_e.q1});
    check("q8",    {24'b0, q8},  {24'b0, got_e.q8});
    check("qc8",   {24'b0, qc8}, {24'b0, ~got_e.q8});
    check("qc1_inv", {31'b0, qc1}, {31'b0, ~q1});
    check("qc8_inv", {24'b0, qc8}, {24'b0, ~q8});
    prev    = got_e;
    started = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // First capture, then steady d=1 up to 50 ns.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'hFF, 1'b0);
    // Reset asserted at 50 ns for five edges, released at 100 ns.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'hFF, 1'b0);
    cycle(1'b0, 1'b0, 8'hFF, 1'b0);
    // Set held five cycles from q=0, d=0, then release.
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    // Glitch on d between edges must not leak through.
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h5A, 1'b1);
    // Reset and set together: reset wins; release both with d=0.
    cycle(1'b0, 1'b0, 8'hFF, 1'b0);
    cycle(1'b1, 1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    // Random traffic with occasional set/reset.
    for (int i = 0; i < 40; i++) begin
      cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
            8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end
    if (exp_q.size() != 0) begin
      check("queue_empty", exp_q.size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
